// File: rtl/max31855_pkg.sv
// Shared definitions for MAX31855 frame decoding and ASCII rendering.
// Frame bit positions, ASCII codes, formatter FSM states, small helpers.
package max31855_pkg;

    localparam int TC_MSB    = 31;
    localparam int TC_LSB    = 18;
    localparam int FAULT_BIT = 16;
    localparam int SCV       = 2;
    localparam int SCG       = 1;
    localparam int OC        = 0;

    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_R     = 8'h52;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SEND
    } fmt_state_e;

    // Absolute value of the 14-bit two's complement temperature.
    // 0x2000 maps to 8192, which still fits in 14 unsigned bits.
    function automatic logic [13:0] tc_magnitude(input logic [13:0] raw);
        return raw[13] ? (~raw + 14'd1) : raw;
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 12-bit binary to 4-digit BCD converter (double-dabble).
// One bit per cycle, exactly 12 cycles from start to done pulse.
module bin2bcd_seq
    import max31855_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset,
    input  logic        start_i,
    input  logic [11:0] bin_i,
    output logic        done_o,
    output logic [15:0] bcd_o
);

    logic [11:0] shift_q, shift_d;
    logic [15:0] bcd_q,   bcd_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        done_q,  done_d;
    logic [3:0]  hun_adj, ten_adj, one_adj;

    function automatic logic [3:0] dabble(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Shift/add-3 step; thousands never reaches 5 before the last
    // shift for a 12-bit input, so it is shifted without adjustment.
    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        hun_adj = dabble(bcd_q[11:8]);
        ten_adj = dabble(bcd_q[7:4]);
        one_adj = dabble(bcd_q[3:0]);
        if (start_i) begin
            shift_d = bin_i;
            bcd_d   = 16'h0000;
            cnt_d   = 4'd12;
        end else if (cnt_q != 4'd0) begin
            bcd_d   = {bcd_q[14:12], hun_adj, ten_adj, one_adj, shift_q[11]};
            shift_d = {shift_q[10:0], 1'b0};
            cnt_d   = cnt_q - 4'd1;
            done_d  = (cnt_q == 4'd1);
        end
    end

    // Conversion state register.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            shift_q <= 12'h000;
            bcd_q   <= 16'h0000;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/max31855_ascii_formatter.sv
// Renders MAX31855 frames as ASCII lines ("+0025.00" or "ERR n")
// and streams them byte-by-byte over a valid/ready handshake.
module max31855_ascii_formatter
    import max31855_pkg::*;
#(
    parameter bit EOL_CRLF = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic [31:0] frame_i,
    input  logic        frame_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic [2:0]  fault_o,
    output logic        frame_drop_o
);

    fmt_state_e  state_q, state_d;
    logic        err_q,   err_d;
    logic        neg_q,   neg_d;
    logic [1:0]  frac_q,  frac_d;
    logic [2:0]  fault_q, fault_d;
    logic        drop_q,  drop_d;
    logic        txv_q,   txv_d;
    logic [7:0]  txd_q,   txd_d;
    logic [3:0]  idx_q,   idx_d;

    logic [13:0] raw_in;
    logic [13:0] mag_in;
    logic        bcd_start;
    logic        bcd_done;
    logic [15:0] bcd;
    logic [3:0]  last_idx;
    logic [3:0]  nxt_idx;
    logic        unused_frame_bits;

    assign raw_in    = frame_i[TC_MSB:TC_LSB];
    assign mag_in    = tc_magnitude(raw_in);
    assign bcd_start = (state_q == ST_IDLE) && frame_valid_i;

    // Reserved and internal-temperature bits carry nothing for this line.
    assign unused_frame_bits = ^{frame_i[17], frame_i[15:3]};

    bin2bcd_seq u_bcd (
        .clk_i   (clk_i),
        .reset   (reset),
        .start_i (bcd_start),
        .bin_i   (mag_in[13:2]),
        .done_o  (bcd_done),
        .bcd_o   (bcd)
    );

    // Character at position idx of the line being sent.
    function automatic logic [7:0] byte_at(
        input logic [3:0]  idx,
        input logic        err,
        input logic        neg,
        input logic [1:0]  frac,
        input logic [15:0] dig,
        input logic [2:0]  flt
    );
        logic [7:0] b;
        b = 8'h00;
        if (err) begin
            case (idx)
                4'd0: b = ASCII_E;
                4'd1: b = ASCII_R;
                4'd2: b = ASCII_R;
                4'd3: b = ASCII_SP;
                4'd4: b = ascii_digit({1'b0, flt});
                4'd5: b = EOL_CRLF ? ASCII_CR : ASCII_LF;
                4'd6: b = ASCII_LF;
                default: b = 8'h00;
            endcase
        end else begin
            case (idx)
                4'd0: b = neg ? ASCII_MINUS : ASCII_PLUS;
                4'd1: b = ascii_digit(dig[15:12]);
                4'd2: b = ascii_digit(dig[11:8]);
                4'd3: b = ascii_digit(dig[7:4]);
                4'd4: b = ascii_digit(dig[3:0]);
                4'd5: b = ASCII_DOT;
                4'd6: begin
                    case (frac)
                        2'd0: b = ascii_digit(4'd0);
                        2'd1: b = ascii_digit(4'd2);
                        2'd2: b = ascii_digit(4'd5);
                        default: b = ascii_digit(4'd7);
                    endcase
                end
                4'd7: b = ascii_digit(frac[0] ? 4'd5 : 4'd0);
                4'd8: b = EOL_CRLF ? ASCII_CR : ASCII_LF;
                4'd9: b = ASCII_LF;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    // Next-state, latch and byte-sequencing logic.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        neg_d    = neg_q;
        frac_d   = frac_q;
        fault_d  = fault_q;
        txv_d    = txv_q;
        txd_d    = txd_q;
        idx_d    = idx_q;
        drop_d   = frame_valid_i && (state_q != ST_IDLE);
        nxt_idx  = idx_q + 4'd1;
        if (err_q) last_idx = EOL_CRLF ? 4'd6 : 4'd5;
        else       last_idx = EOL_CRLF ? 4'd9 : 4'd8;

        case (state_q)
            ST_IDLE: begin
                if (frame_valid_i) begin
                    err_d   = frame_i[FAULT_BIT];
                    neg_d   = raw_in[13];
                    frac_d  = mag_in[1:0];
                    fault_d = {frame_i[SCV], frame_i[SCG], frame_i[OC]};
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (bcd_done) begin
                    state_d = ST_SEND;
                    idx_d   = 4'd0;
                    txv_d   = 1'b1;
                    txd_d   = byte_at(4'd0, err_q, neg_q, frac_q, bcd, fault_q);
                end
            end
            ST_SEND: begin
                if (txv_q && tx_ready_i) begin
                    if (idx_q == last_idx) begin
                        state_d = ST_IDLE;
                        txv_d   = 1'b0;
                        txd_d   = 8'h00;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = nxt_idx;
                        txd_d = byte_at(nxt_idx, err_q, neg_q, frac_q, bcd, fault_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            neg_q   <= 1'b0;
            frac_q  <= 2'd0;
            fault_q <= 3'd0;
            drop_q  <= 1'b0;
            txv_q   <= 1'b0;
            txd_q   <= 8'h00;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            neg_q   <= neg_d;
            frac_q  <= frac_d;
            fault_q <= fault_d;
            drop_q  <= drop_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
            idx_q   <= idx_d;
        end
    end

    assign tx_data_o    = txd_q;
    assign tx_valid_o   = txv_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign fault_o      = fault_q;
    assign frame_drop_o = drop_q;

endmodule

// File: doc/max31855_ascii_formatter.md
Name: max31855_ascii_formatter

Overview:
- Downstream consumer of the MAX31855 SPI master's 32-bit SPI_Data_Out frame.
- Decodes the 14-bit signed thermocouple temperature (0.25 °C LSB) or the fault bits, and renders a fixed-format ASCII line.
- Streams the line byte-by-byte to the UART transmitter over a valid/ready handshake.
- Binary-to-decimal conversion is sequential (double-dabble), not combinational.

Parameters:
- EOL_CRLF, 1, 1: line ends "\r\n"; 0: line ends "\n" only.

Ports:
- clk_i  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_i  in  32  MAX31855 frame; D31..D18 TC temp, D16 fault, D2 SCV, D1 SCG, D0 OC
- frame_valid_i  in  1  one-cycle strobe; frame_i valid this cycle
- tx_data_o  out  8  ASCII byte to UART
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  UART accepts byte on an edge where tx_valid_o && tx_ready_i
- busy_o  out  1  frame in conversion or transmission
- fault_o  out  3  {SCV,SCG,OC} of last accepted frame
- frame_drop_o  out  1  one-cycle pulse: frame_valid_i arrived while busy

Behaviour:
- Reset values: tx_data_o=0x00, tx_valid_o=0, busy_o=0, fault_o=0, frame_drop_o=0, FSM=IDLE.
- Reset mid-operation: the partial line is abandoned; tx_valid_o is low after the reset edge.
- FSM: IDLE -> CONV -> SEND -> IDLE.
- IDLE:
  - On frame_valid_i, latch frame_i; fault_o <= frame_i[2:0]; busy_o=1; go to CONV.
  - Acceptance is on the same edge as the strobe.
- CONV:
  - Fixed 12 cycles of double-dabble on the 12-bit integer magnitude, for fault frames too (uniform latency).
  - Magnitude = raw when raw[13]=0, else (~raw+1) computed in 14 bits.
  - raw=0x2000 gives magnitude 8192; integer = mag[13:2], range 0..2048; frac = mag[1:0].
- Latency: if the accept edge is N, tx_valid_o first rises after edge N+13.
- SEND, normal frame (D16=0):
  - sign ('+' when raw[13]=0, else '-'), 4 integer digits with leading zeros, '.', frac digits ("00","25","50","75"), EOL.
  - 10 bytes with CRLF, 9 without.
  - Negative zero is impossible: raw=0 renders as "+".
- SEND, fault frame (D16=1):
  - "ERR ", then ASCII '0'+frame[2:0], then EOL.
  - 7 bytes with CRLF, 6 without.
  - Temperature is ignored.
- Handshake:
  - tx_data_o and tx_valid_o are held stable until accepted.
  - The byte index advances only on an edge with tx_valid_o && tx_ready_i.
  - tx_ready_i held low stalls indefinitely with no byte change.
  - tx_valid_o may assert without waiting for tx_ready_i.
- End of line: on acceptance of the final byte, tx_valid_o=0 and busy_o=0 on that same edge; FSM returns to IDLE.
- A frame_valid_i in the cycle after busy_o falls is accepted normally.
- frame_valid_i while busy_o=1: the frame is discarded and frame_drop_o pulses for one cycle. There is no queueing, and the current line is unaffected.
- Simultaneous final-byte acceptance and frame_valid_i on the same edge: the frame is dropped, since busy_o was 1.

Decomposition:
- Shared package max31855_pkg:
  - frame bit-position constants: TC_MSB=31, TC_LSB=18, FAULT_BIT=16, SCV=2, SCG=1, OC=0.
  - ASCII constants: '+', '-', '.', 'E', 'R', ' ', '0', CR=0x0D, LF=0x0A.
  - FSM state typedef.
- One sub-module, bin2bcd_seq:
  - 12-bit input, start/done, 4x4-bit BCD out, exactly 12 cycles.
  - Reused by later display blocks.
- The byte mux and sequencer stay in the top module.

Test Plan:
- frame 0x01900000 (raw 100), tx_ready_i=1 -> "+0025.00\r\n", first tx_valid_o 13 cycles after the accept edge, busy_o drops with LF.
- frame 0xFFFC0000 (raw 0x3FFF) -> "-0000.25\r\n"; frame 0x7FFC0000 -> "+2047.75\r\n"; frame 0x80000000 -> "-2048.00\r\n".
- frame 0x00010001 -> "ERR 1\r\n", fault_o=3'b001; with EOL_CRLF=0 -> "ERR 1\n".
- tx_ready_i low for 5 cycles while byte 3 is presented -> tx_data_o held at '0' with tx_valid_o=1, no skipped or duplicated bytes; frame_valid_i pulsed during the line -> frame_drop_o one-cycle pulse, only the original line emitted.
- reset asserted after 4 bytes are accepted -> tx_valid_o=0 and busy_o=0 next cycle; next frame 0x00000000 -> complete "+0000.00\r\n".
